// File: rtl/seg_disp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg_disp_pkg
//  Description : Shared types and constants for the HEX word display path.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg_disp_pkg;

  // Display mode, also shown on the board LEDs
  typedef enum logic [1:0] {
    S_LO     = 2'd0,
    S_HI     = 2'd1,
    S_SCROLL = 2'd2
  } mode_e;

  localparam int NUM_DIGITS   = 6;
  localparam int RING_LEN     = 10;
  localparam int NIB_PER_WORD = 8;

  // Nibble n of a 32-bit word (n0 = [3:0])
  function automatic logic [3:0] get_nib(input logic [31:0] w, input int n);
    return w[4*n +: 4];
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : 2-FF synchronizer, stable-level debouncer and rising-edge
//                press pulse for a raw asynchronous push button.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
  parameter int DB_CYC = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_press
);

  localparam int              CNT_W    = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYC - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             r_press;

  // Bring the asynchronous button into the clk domain
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a new level only after it has differed for DB_CYC consecutive
  // cycles; any return to the accepted level restarts the count. The press
  // pulse fires on the same edge the accepted level goes 0->1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_level <= 1'b0;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (r_sync2 != r_level) begin
        if (r_cnt == CNT_LAST) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
          r_press <= r_sync2;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/hex_word_display.sv
`default_nettype none
// ============================================================================
//  Module      : hex_word_display
//  Description : Captures a 32-bit debug word over valid/ready and selects
//                which nibbles drive the six HEX digits (low page, high page
//                or auto-scroll over a 10-position ring), with blank flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module hex_word_display
  import seg_disp_pkg::*;
#(
  parameter int DB_CYC     = 500000,
  parameter int SCROLL_CYC = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        freeze,
  input  logic        lz_en,
  input  logic        scroll_en,
  input  logic        page_btn,
  output logic [23:0] nibble_o,
  output logic [5:0]  blank_o,
  output logic [1:0]  page_o
);

  localparam int              SC_W    = (SCROLL_CYC > 1) ? $clog2(SCROLL_CYC) : 1;
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCROLL_CYC - 1);

  logic [31:0]     r_word;
  mode_e           r_mode;
  mode_e           w_mode_nxt;
  logic [3:0]      r_offset;
  logic [SC_W-1:0] r_scnt;
  logic            w_press;
  logic [23:0]     w_nib;
  logic [5:0]      w_blk;
  logic            w_lead;
  logic [4:0]      w_pos;
  logic [23:0]     r_nib;
  logic [5:0]      r_blk;

  assign in_ready = ~freeze;

  btn_debounce #(
    .DB_CYC (DB_CYC)
  ) u_btn (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (page_btn),
    .o_press (w_press)
  );

  // Capture the word on an accepted handshake; no buffering when not ready
  always_ff @(posedge clk) begin
    if (rst) begin
      r_word <= '0;
    end else if (in_valid && in_ready) begin
      r_word <= in_data;
    end
  end

  // Mode state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode <= S_LO;
    end else begin
      r_mode <= w_mode_nxt;
    end
  end

  // Mode transitions; scroll_en outranks a press in the same cycle
  always_comb begin
    w_mode_nxt = r_mode;
    case (r_mode)
      S_LO: begin
        if (scroll_en)    w_mode_nxt = S_SCROLL;
        else if (w_press) w_mode_nxt = S_HI;
      end
      S_HI: begin
        if (scroll_en)    w_mode_nxt = S_SCROLL;
        else if (w_press) w_mode_nxt = S_LO;
      end
      S_SCROLL: begin
        if (!scroll_en)   w_mode_nxt = S_LO;
      end
      default: w_mode_nxt = S_LO;
    endcase
  end

  // Scroll timer and ring offset; both restart on entry to scroll mode
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scnt   <= '0;
      r_offset <= '0;
    end else if (w_mode_nxt == S_SCROLL && r_mode != S_SCROLL) begin
      r_scnt   <= '0;
      r_offset <= '0;
    end else if (r_mode == S_SCROLL) begin
      if (r_scnt == SC_LAST) begin
        r_scnt   <= '0;
        r_offset <= (r_offset == 4'(RING_LEN - 1)) ? 4'd0 : r_offset + 4'd1;
      end else begin
        r_scnt <= r_scnt + 1'b1;
      end
    end
  end

  // Digit selection and blanking for the current word, mode and offset.
  // Blanked digits outside the low page carry a zero nibble.
  always_comb begin
    w_nib  = '0;
    w_blk  = '0;
    w_lead = 1'b0;
    w_pos  = '0;
    case (r_mode)
      S_LO: begin
        for (int d = 0; d < NUM_DIGITS; d++) begin
          w_nib[4*d +: 4] = get_nib(r_word, d);
        end
        // Blank from d5 down while zero; d0 always stays lit
        w_lead = lz_en;
        for (int d = NUM_DIGITS - 1; d > 0; d--) begin
          if (w_lead && get_nib(r_word, d) == 4'd0) begin
            w_blk[d] = 1'b1;
          end else begin
            w_lead = 1'b0;
          end
        end
      end
      S_HI: begin
        w_blk[5:2]  = 4'b1111;
        w_nib[7:4]  = get_nib(r_word, 7);
        w_nib[3:0]  = get_nib(r_word, 6);
        w_blk[1]    = lz_en && (get_nib(r_word, 7) == 4'd0);
      end
      S_SCROLL: begin
        // Digit d5-k shows ring[(offset+k) mod 10]; ring r<8 holds n(7-r)
        for (int k = 0; k < NUM_DIGITS; k++) begin
          w_pos = {1'b0, r_offset} + 5'(k);
          if (w_pos >= 5'(RING_LEN)) begin
            w_pos = w_pos - 5'(RING_LEN);
          end
          if (w_pos < 5'(NIB_PER_WORD)) begin
            w_nib[4*(NUM_DIGITS-1-k) +: 4] = get_nib(r_word, NIB_PER_WORD - 1 - int'(w_pos));
          end else begin
            w_blk[NUM_DIGITS-1-k] = 1'b1;
          end
        end
      end
      default: begin
        w_nib = '0;
        w_blk = '0;
      end
    endcase
  end

  // Register the digit outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_nib <= '0;
      r_blk <= '0;
    end else begin
      r_nib <= w_nib;
      r_blk <= w_blk;
    end
  end

  assign nibble_o = r_nib;
  assign blank_o  = r_blk;
  assign page_o   = r_mode;

endmodule
`default_nettype wire

// File: tb/tb_hex_word_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hex_word_display
//  Description : Scoreboard bench for hex_word_display (DB_CYC=4,
//                SCROLL_CYC=8) with hand-computed directed expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hex_word_display;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        freeze;
  logic        lz_en;
  logic        scroll_en;
  logic        page_btn;
  logic [23:0] nibble_o;
  logic [5:0]  blank_o;
  logic [1:0]  page_o;

  typedef struct {
    string       name;
    logic [23:0] nib;
    logic [5:0]  blk;
    logic [1:0]  pg;
    logic        rdy;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [1:0] P_LO = 2'd0;
  localparam logic [1:0] P_HI = 2'd1;
  localparam logic [1:0] P_SC = 2'd2;

  hex_word_display #(
    .DB_CYC     (4),
    .SCROLL_CYC (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .freeze    (freeze),
    .lz_en     (lz_en),
    .scroll_en (scroll_en),
    .page_btn  (page_btn),
    .nibble_o  (nibble_o),
    .blank_o   (blank_o),
    .page_o    (page_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare the display against the oldest pending expectation
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (nibble_o !== e.nib || blank_o !== e.blk || page_o !== e.pg || in_ready !== e.rdy) begin
        errors++;
        $display("FAIL %s: got nib=%h blank=%b page=%0d ready=%b, expected nib=%h blank=%b page=%0d ready=%b",
                 e.name, nibble_o, blank_o, page_o, in_ready, e.nib, e.blk, e.pg, e.rdy);
      end
    end
  end

  // Global guard against a hung run
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input string name, input logic [23:0] nib, input logic [5:0] blk,
                            input logic [1:0] pg, input logic rdy);
    exp_t e;
    e.name = name; e.nib = nib; e.blk = blk; e.pg = pg; e.rdy = rdy;
    sb.push_back(e);
    @(negedge clk);
    #1;
  endtask

  // One-cycle valid, then wait for the display to reflect it
  task automatic send(input logic [31:0] w);
    in_valid = 1'b1;
    in_data  = w;
    cyc(1);
    in_valid = 1'b0;
    cyc(1);
  endtask

  // Button held for hi cycles, then released; 16 edges in total
  task automatic button(input int hi);
    page_btn = 1'b1;
    cyc(hi);
    page_btn = 1'b0;
    cyc(16 - hi);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; freeze = 1'b0;
    lz_en = 1'b0; scroll_en = 1'b0; page_btn = 1'b0;
    cyc(2);
    rst = 1'b0;
    expect_now("reset", 24'h000000, 6'b000000, P_LO, 1'b1);

    // Basic capture and low page
    in_valid = 1'b1;
    in_data  = 32'h1234ABCD;
    expect_now("ready_idle", 24'h000000, 6'b000000, P_LO, 1'b1);
    cyc(1);
    in_valid = 1'b0;
    cyc(1);
    expect_now("lo_page", 24'h34ABCD, 6'b000000, P_LO, 1'b1);

    // Leading-zero blanking
    lz_en = 1'b1;
    send(32'h000000A0);
    expect_now("lz_a0", 24'h0000A0, 6'b111100, P_LO, 1'b1);
    send(32'h00000000);
    expect_now("lz_zero", 24'h000000, 6'b111110, P_LO, 1'b1);
    lz_en = 1'b0;

    // Paging via the debounced button
    send(32'h1234ABCD);
    expect_now("lo_again", 24'h34ABCD, 6'b000000, P_LO, 1'b1);
    button(6);
    expect_now("hi_page", 24'h000012, 6'b111100, P_HI, 1'b1);
    button(2);
    expect_now("glitch", 24'h000012, 6'b111100, P_HI, 1'b1);
    button(6);
    expect_now("back_lo", 24'h34ABCD, 6'b000000, P_LO, 1'b1);

    // Scroll mode over the 10-position ring
    scroll_en = 1'b1;
    cyc(2);
    expect_now("scroll_0", 24'h1234AB, 6'b000000, P_SC, 1'b1);
    cyc(32);
    expect_now("scroll_4", 24'hABCD00, 6'b000011, P_SC, 1'b1);
    cyc(32);
    expect_now("scroll_8", 24'h001234, 6'b110000, P_SC, 1'b1);
    cyc(16);
    expect_now("scroll_10", 24'h1234AB, 6'b000000, P_SC, 1'b1);
    button(6);
    expect_now("scroll_press", 24'h34ABCD, 6'b000000, P_SC, 1'b1);
    scroll_en = 1'b0;
    cyc(2);
    expect_now("scroll_exit", 24'h34ABCD, 6'b000000, P_LO, 1'b1);

    // Freeze refuses new words
    freeze = 1'b1;
    expect_now("freeze_ready", 24'h34ABCD, 6'b000000, P_LO, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'hFFFFFFFF;
    cyc(3);
    expect_now("freeze_hold", 24'h34ABCD, 6'b000000, P_LO, 1'b0);
    freeze = 1'b0;
    cyc(1);
    in_valid = 1'b0;
    cyc(1);
    expect_now("unfreeze", 24'hFFFFFF, 6'b000000, P_LO, 1'b1);

    // Reset in the middle of scrolling
    send(32'h1234ABCD);
    scroll_en = 1'b1;
    cyc(43);
    expect_now("scroll_5", 24'hBCD001, 6'b000110, P_SC, 1'b1);
    rst = 1'b1;
    scroll_en = 1'b0;
    cyc(1);
    expect_now("mid_reset", 24'h000000, 6'b000000, P_LO, 1'b1);
    rst = 1'b0;
    send(32'h1234ABCD);
    expect_now("post_reset", 24'h34ABCD, 6'b000000, P_LO, 1'b1);

    // Drain the scoreboard with a bound
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hex_word_display.md
Name: hex_word_display

Overview:
- Upstream stage of the per-digit 7-segment decoders.
- Captures a 32-bit debug word from the CPU side through a valid/ready handshake.
- Selects which nibbles appear on the six HEX digits: low page, high page, or auto-scroll.
- Drives one 4-bit nibble plus one blank flag per digit. Top level forces the segments of blanked digits to all-off (7'b1111111).

Parameters:
DB_CYC, 500000, clock cycles the button level must be stable before it is accepted (10 ms at 50 MHz)
SCROLL_CYC, 25000000, clock cycles between scroll steps (0.5 s at 50 MHz)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  in_data valid
in_ready  out  1  block accepts in_data this cycle
in_data  in  32  word to display; nibble n7 = [31:28] … n0 = [3:0]
freeze  in  1  hold the current word and refuse new ones
lz_en  in  1  leading-zero blanking enable (paged modes only)
scroll_en  in  1  level input selecting scroll mode
page_btn  in  1  raw asynchronous push button, active-high
nibble_o  out  24  digit d uses bits [4d+3:4d]; d5 is leftmost
blank_o  out  6  bit d=1 means digit d is dark
page_o  out  2  current mode (for LEDs)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. All state is updated on the rising edge of clk.
- Reset state: word_q=0, mode=S_LO, offset=0, scroll counter=0, debouncer accepted level=0. Outputs nibble_o=0, blank_o=0, page_o=S_LO.
- Handshake:
  - in_ready = ~freeze (combinational).
  - On in_valid&in_ready, word_q <= in_data. in_valid with in_ready=0 is ignored; there is no buffering.
- Output timing: nibble_o and blank_o are registered and computed from the current word_q, mode and offset.
  - Latency from the capture edge to the display: 1 further cycle (visible 2 edges after in_valid is sampled).
- Button path:
  - 2-FF synchronizer feeds a debouncer.
  - A differing synchronized level must persist for DB_CYC consecutive cycles before it becomes the accepted level. Any bounce restarts the count.
  - A 0→1 change of the accepted level produces a 1-cycle press pulse.
- Mode FSM (S_LO, S_HI, S_SCROLL):
  - S_LO: press → S_HI; scroll_en=1 → S_SCROLL.
  - S_HI: press → S_LO; scroll_en=1 → S_SCROLL.
  - S_SCROLL: scroll_en=0 → S_LO. Presses are ignored.
  - scroll_en has priority over a press in the same cycle.
  - Entering S_SCROLL clears offset and the scroll counter.
- S_LO display: d5..d0 = n5..n0.
  - With lz_en=1, blank d5 downward while the nibble is 0, stopping at the first nonzero nibble. d0 is never blanked.
- S_HI display: d5..d2 are blanked; d1 = n7, d0 = n6.
  - With lz_en=1, d1 is blanked if n7=0.
- S_SCROLL display: virtual ring of 10 positions. Position r = 0..7 holds n(7−r); r = 8 and 9 are blank.
  - Digit d5−k shows ring[(offset+k) mod 10], k = 0..5.
  - lz_en has no effect in this mode.
  - The counter counts 0..SCROLL_CYC−1. On wrap, offset increments; 9 wraps to 0.
- Simultaneous events: a capture and a mode change in the same cycle both take effect, and the next display uses both.
- freeze does not stop scrolling or paging.
- Reset mid-scroll or mid-debounce returns every state to its reset value in the next cycle.
- Widths: offset is 4 bits and counts 0..9 only. The counter width is $clog2(SCROLL_CYC); the debounce counter width is $clog2(DB_CYC).

Decomposition:
- Package seg_disp_pkg holds:
  - mode enum mode_e {S_LO, S_HI, S_SCROLL} (2 bits)
  - NUM_DIGITS=6, RING_LEN=10, NIB_PER_WORD=8
- One sub-module, btn_debounce (synchronizer + debouncer + press pulse, parameter DB_CYC), reusable for other board buttons.
- Ring/blank selection stays in hex_word_display.

Test Plan:
All tests use DB_CYC=4, SCROLL_CYC=8.
1. Reset; freeze=0, lz_en=0; in_valid=1 with 0x1234ABCD for 1 cycle → in_ready=1; two edges later nibble_o digits d5..d0 = 3,4,A,B,C,D and blank_o=000000.
2. lz_en=1, capture 0x000000A0 → d1=A, d0=0, blank_o=111100. Capture 0x0 → blank_o=111110 (d0 shows 0).
3. Word 0x1234ABCD:
   - page_btn high for 6 cycles → one press; page_o=S_HI; d1=1, d0=2; blank_o=111100.
   - 2-cycle glitch → no mode change.
   - Second valid press → S_LO.
4. scroll_en=1 with 0x1234ABCD:
   - Immediately → 1,2,3,4,A,B.
   - After 4 steps (32 cycles) → A,B,C,D with blank_o=000011.
   - After 8 steps → blank,blank,1,2,3,4 (blank_o=110000).
   - After 10 steps → back to 1,2,3,4,A,B.
   - A press during scroll has no effect.
5. freeze=1 → in_ready=0. in_valid with 0xFFFFFFFF is ignored and the display stays 3,4,A,B,C,D. Release freeze and present it → it is captured.
6. Assert rst during S_SCROLL at offset 5 → next cycle page_o=S_LO, nibble_o=0, blank_o=0. A following capture behaves as in test 1.
